bsg_mux_bitwise_rmw_ctrl: RTL

BSG_MUX_BITWISE_RMW_CTRL -- requirements
Module: bsg_mux_bitwise_rmw_ctrl

---
 rtl/bsg_mux_bitwise_rmw_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/bsg_mux_bitwise_rmw_ctrl.sv
// Bitwise read-modify-write controller: merges masked data into one memory word.
// Partial masks read then write; all-ones masks write directly; all-zero masks complete at once.
module bsg_mux_bitwise_rmw_ctrl #(
  parameter int width_p      = 128,
  parameter int addr_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic [width_p-1:0]      mask_i,
  output logic                    mem_v_o,
  output logic                    mem_w_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  output logic [width_p-1:0]      mem_data_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_data_v_i,
  input  logic [width_p-1:0]      mem_data_i,
  output logic                    done_v_o,
  input  logic                    done_yumi_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]              state;
  logic [2:0]              state_n;
  logic [addr_width_p-1:0] addr_r;
  logic [width_p-1:0]      data_r;
  logic [width_p-1:0]      mask_r;
  logic [width_p-1:0]      merged_r;
  logic                    accept;
  logic                    mask_zero;
  logic                    mask_ones;

  assign accept    = v_i & ready_o;
  assign mask_zero = ~|mask_i;
  assign mask_ones = &mask_i;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            mask_zero: state_n = DONE;
            mask_ones: state_n = WR_REQ;
            default:   state_n = RD_REQ;
          endcase
        end
      end
      RD_REQ:  if (mem_ready_i) state_n = RD_WAIT;
      RD_WAIT: if (mem_data_v_i) state_n = WR_REQ;
      WR_REQ:  if (mem_ready_i) state_n = DONE;
      DONE:    if (done_yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      addr_r   <= '0;
      data_r   <= '0;
      mask_r   <= '0;
      merged_r <= '0;
    end else begin
      state <= state_n;
      // Seeding merged with data_i covers the all-ones path that skips the read.
      if (accept) begin
        addr_r   <= addr_i;
        data_r   <= data_i;
        mask_r   <= mask_i;
        merged_r <= data_i;
      end else if (state == RD_WAIT && mem_data_v_i) begin
        merged_r <= (mask_r & data_r) | (~mask_r & mem_data_i);
      end
    end
  end

  // Gating with reset keeps ready low for the whole reset window.
  assign ready_o    = reset_n_i & (state == IDLE);
  assign mem_v_o    = (state == RD_REQ) | (state == WR_REQ);
  assign mem_w_o    = (state == WR_REQ);
  assign mem_addr_o = addr_r;
  assign mem_data_o = merged_r;
  assign done_v_o   = (state == DONE);

endmodule
